// File: rtl/pattern_pwm_pkg.sv
// rtl/pattern_pwm_pkg.sv - shared states, default widths and config record for the pattern PWM bank
package pattern_pwm_pkg;

  localparam int DEF_NUM_CHANNELS = 4;
  localparam int DEF_PAT_WIDTH    = 32;
  localparam int DEF_DUTY_W       = 8;
  localparam int DEF_GAP_W        = 16;
  localparam int DEF_NUM_W        = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BIT  = 2'd1,
    ST_GAP  = 2'd2
  } pwm_state_e;

  // Register-map view of one channel's shadow configuration at default widths.
  typedef struct packed {
    logic [DEF_PAT_WIDTH-1:0] pat;
    logic [DEF_DUTY_W-1:0]    duty;
    logic [DEF_GAP_W-1:0]     gap;
    logic [DEF_NUM_W-1:0]     num;
`ifdef PATTERN_PWM_BANK_POLARITY_EN
    logic                     pol;
`endif
  } pwm_cfg_t;

endpackage

// File: rtl/pattern_pwm_chan.sv
// rtl/pattern_pwm_chan.sv - one pattern PWM channel: shadow config, IDLE/BIT/GAP FSM, counters
module pattern_pwm_chan
  import pattern_pwm_pkg::*;
#(
  parameter int PAT_WIDTH = DEF_PAT_WIDTH,
  parameter int DUTY_W    = DEF_DUTY_W,
  parameter int GAP_W     = DEF_GAP_W,
  parameter int NUM_W     = DEF_NUM_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_we,
  input  logic [PAT_WIDTH-1:0] cfg_pat,
  input  logic [DUTY_W-1:0]    cfg_duty,
  input  logic [GAP_W-1:0]     cfg_gap,
  input  logic [NUM_W-1:0]     cfg_num,
`ifdef PATTERN_PWM_BANK_POLARITY_EN
  input  logic                 cfg_pol,
`endif
  input  logic                 start,
  input  logic                 stop,
  output logic                 pwm_out,
  output logic                 busy,
  output logic                 done
);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_BIT  = ST_BIT;
  localparam logic [1:0] S_GAP  = ST_GAP;
  localparam int BCW = (PAT_WIDTH > 1) ? $clog2(PAT_WIDTH) : 1;

  logic [PAT_WIDTH-1:0] sh_pat, act_pat, shift_q;
  logic [DUTY_W-1:0]    sh_duty, act_duty, duty_cnt;
  logic [GAP_W-1:0]     sh_gap, act_gap, gap_cnt;
  logic [NUM_W-1:0]     sh_num, act_num, burst_cnt, burst_next;
  logic [BCW-1:0]       bit_cnt;
  logic [1:0]           state;
  logic                 pwm_q, done_q;
  logic                 duty_last, bit_last, gap_last, eob, run_over;

  // duty = 0 behaves as duty = 1: every clock ends the bit.
  assign duty_last  = (act_duty == '0) || (duty_cnt == act_duty - 1'b1);
  assign bit_last   = (bit_cnt == BCW'(PAT_WIDTH - 1));
  assign gap_last   = (gap_cnt == act_gap - 1'b1);
  assign eob        = ((state == S_BIT) && duty_last && bit_last && (act_gap == '0))
                   || ((state == S_GAP) && gap_last);
  assign burst_next = burst_cnt + 1'b1;
  assign run_over   = (act_num != '0) && (burst_next == act_num);

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_pat    <= '0;
      sh_duty   <= DUTY_W'(1);
      sh_gap    <= '0;
      sh_num    <= NUM_W'(1);
      act_pat   <= '0;
      act_duty  <= DUTY_W'(1);
      act_gap   <= '0;
      act_num   <= NUM_W'(1);
      shift_q   <= '0;
      duty_cnt  <= '0;
      gap_cnt   <= '0;
      burst_cnt <= '0;
      bit_cnt   <= '0;
      state     <= S_IDLE;
      pwm_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // Shadow only; the running burst keeps its own active copy.
      if (cfg_we) begin
        sh_pat  <= cfg_pat;
        sh_duty <= cfg_duty;
        sh_gap  <= cfg_gap;
        sh_num  <= cfg_num;
      end
      if (stop) begin
        state <= S_IDLE;
        pwm_q <= 1'b0;
      end else if (eob) begin
        burst_cnt <= burst_next;
        if (run_over) begin
          state  <= S_IDLE;
          pwm_q  <= 1'b0;
          done_q <= 1'b1;
        end else begin
          state    <= S_BIT;
          shift_q  <= act_pat;
          pwm_q    <= act_pat[PAT_WIDTH-1];
          bit_cnt  <= '0;
          duty_cnt <= '0;
        end
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              act_pat   <= sh_pat;
              act_duty  <= sh_duty;
              act_gap   <= sh_gap;
              act_num   <= sh_num;
              shift_q   <= sh_pat;
              pwm_q     <= sh_pat[PAT_WIDTH-1];
              duty_cnt  <= '0;
              bit_cnt   <= '0;
              burst_cnt <= '0;
              state     <= S_BIT;
            end
          end
          S_BIT: begin
            if (duty_last) begin
              duty_cnt <= '0;
              if (bit_last) begin
                state   <= S_GAP;
                gap_cnt <= '0;
                pwm_q   <= 1'b0;
              end else begin
                shift_q <= shift_q << 1;
                bit_cnt <= bit_cnt + 1'b1;
                pwm_q   <= shift_q[PAT_WIDTH-2];
              end
            end else begin
              duty_cnt <= duty_cnt + 1'b1;
            end
          end
          S_GAP: begin
            gap_cnt <= gap_cnt + 1'b1;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign busy = (state != S_IDLE);
  assign done = done_q;

`ifdef PATTERN_PWM_BANK_POLARITY_EN
  logic sh_pol, act_pol;

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_pol  <= 1'b0;
      act_pol <= 1'b0;
    end else begin
      if (cfg_we) sh_pol <= cfg_pol;
      if (!stop && (state == S_IDLE) && start) act_pol <= sh_pol;
    end
  end

  // Idle level follows the shadow so the line settles before the next start.
  assign pwm_out = pwm_q ^ (busy ? act_pol : sh_pol);
`else
  assign pwm_out = pwm_q;
`endif

endmodule

// File: rtl/pattern_pwm_bank.sv
// rtl/pattern_pwm_bank.sv - multi-channel pattern PWM bank top; optional PATTERN_PWM_BANK_POLARITY_EN adds cfg_pol
module pattern_pwm_bank
  import pattern_pwm_pkg::*;
#(
  parameter int NUM_CHANNELS = DEF_NUM_CHANNELS,
  parameter int PAT_WIDTH    = DEF_PAT_WIDTH,
  parameter int DUTY_W       = DEF_DUTY_W,
  parameter int GAP_W        = DEF_GAP_W,
  parameter int NUM_W        = DEF_NUM_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_we,
  input  logic [(NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1)-1:0] cfg_ch,
  input  logic [PAT_WIDTH-1:0]    cfg_pat,
  input  logic [DUTY_W-1:0]       cfg_duty,
  input  logic [GAP_W-1:0]        cfg_gap,
  input  logic [NUM_W-1:0]        cfg_num,
`ifdef PATTERN_PWM_BANK_POLARITY_EN
  input  logic                    cfg_pol,
`endif
  input  logic [NUM_CHANNELS-1:0] start_mask,
  input  logic [NUM_CHANNELS-1:0] stop_mask,
  output logic [NUM_CHANNELS-1:0] pwm_out,
  output logic [NUM_CHANNELS-1:0] busy,
  output logic [NUM_CHANNELS-1:0] done
);

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_chan
    logic ch_we;

    // Channel indices beyond NUM_CHANNELS-1 match no instance and are dropped.
    assign ch_we = cfg_we && (int'(cfg_ch) == i);

    pattern_pwm_chan #(
      .PAT_WIDTH (PAT_WIDTH),
      .DUTY_W    (DUTY_W),
      .GAP_W     (GAP_W),
      .NUM_W     (NUM_W)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .cfg_we   (ch_we),
      .cfg_pat  (cfg_pat),
      .cfg_duty (cfg_duty),
      .cfg_gap  (cfg_gap),
      .cfg_num  (cfg_num),
`ifdef PATTERN_PWM_BANK_POLARITY_EN
      .cfg_pol  (cfg_pol),
`endif
      .start    (start_mask[i]),
      .stop     (stop_mask[i]),
      .pwm_out  (pwm_out[i]),
      .busy     (busy[i]),
      .done     (done[i])
    );
  end

endmodule

// File: tb/tb_pattern_pwm_bank.sv
// tb/tb_pattern_pwm_bank.sv - directed self-checking bench for pattern_pwm_bank
module tb_pattern_pwm_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [31:0] cfg_pat;
  logic [7:0]  cfg_duty;
  logic [15:0] cfg_gap;
  logic [7:0]  cfg_num;
`ifdef PATTERN_PWM_BANK_POLARITY_EN
  logic        cfg_pol;
`endif
  logic [3:0]  start_mask;
  logic [3:0]  stop_mask;
  logic [3:0]  pwm_out;
  logic [3:0]  busy;
  logic [3:0]  done;

  int tests = 0;
  int fails = 0;

  pattern_pwm_bank dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_pat    (cfg_pat),
    .cfg_duty   (cfg_duty),
    .cfg_gap    (cfg_gap),
    .cfg_num    (cfg_num),
`ifdef PATTERN_PWM_BANK_POLARITY_EN
    .cfg_pol    (cfg_pol),
`endif
    .start_mask (start_mask),
    .stop_mask  (stop_mask),
    .pwm_out    (pwm_out),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic write_cfg(input int ch, input logic [31:0] pat, input int duty, input int gap, input int num);
    cfg_we   = 1'b1;
    cfg_ch   = ch[1:0];
    cfg_pat  = pat;
    cfg_duty = duty[7:0];
    cfg_gap  = gap[15:0];
    cfg_num  = num[7:0];
    tick();
    cfg_we   = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] t2_pat;
    logic        e;
    int          p;

    rst = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_pat = '0; cfg_duty = '0;
    cfg_gap = '0; cfg_num = '0; start_mask = '0; stop_mask = '0;
`ifdef PATTERN_PWM_BANK_POLARITY_EN
    cfg_pol = 1'b0;
`endif
    tick(); tick();
    chk("rst_pwm", 32'(pwm_out), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    rst = 1'b0;
    tick();

    // Single burst on ch0: 1,1,0,0,1,1 then zeros; done at cycle 69.
    write_cfg(0, 32'hA000_0000, 2, 4, 1);
    start_mask = 4'b0001; tick(); start_mask = '0;
    for (int k = 1; k <= 68; k++) begin
      e = (k == 1) || (k == 2) || (k == 5) || (k == 6);
      chk($sformatf("t1_pwm_c%0d", k), 32'(pwm_out[0]), 32'(e));
      chk($sformatf("t1_busy_c%0d", k), 32'({busy[0], done[0]}), 32'h2);
      tick();
    end
    chk("t1_done_c69", 32'(done), 32'h1);
    chk("t1_busy_c69", 32'(busy), 32'h0);
    chk("t1_pwm_c69", 32'(pwm_out), 32'h0);
    tick();
    chk("t1_done_c70", 32'(done), 32'h0);

    // All four channels started together: lock-step outputs, two 34-clock bursts.
    t2_pat = 32'hC000_0001;
    for (int c = 0; c < 4; c++) write_cfg(c, t2_pat, 1, 2, 2);
    start_mask = 4'b1111; tick(); start_mask = '0;
    for (int k = 1; k <= 68; k++) begin
      p = (k - 1) % 34;
      e = (p < 32) ? t2_pat[31 - p] : 1'b0;
      chk($sformatf("t2_pwm_c%0d", k), 32'(pwm_out), 32'({4{e}}));
      chk($sformatf("t2_busy_c%0d", k), 32'({busy, done}), 32'hF0);
      tick();
    end
    chk("t2_done", 32'(done), 32'hF);
    chk("t2_busy_end", 32'(busy), 32'h0);

    // Infinite mode on ch1, then abort.
    write_cfg(1, 32'hFFFF_0000, 1, 0, 0);
    start_mask = 4'b0010; tick(); start_mask = '0;
    for (int k = 1; k <= 1000; k++) begin
      e = ((k - 1) % 32) < 16;
      chk($sformatf("t3_c%0d", k), 32'({pwm_out[1], busy[1], done[1]}), 32'({e, 1'b1, 1'b0}));
      tick();
    end
    stop_mask = 4'b0010; tick(); stop_mask = '0;
    chk("t3_stop", 32'({pwm_out[1], busy[1], done[1]}), 32'h0);

    // ch2 collisions: start+stop, then cfg write alongside start.
    write_cfg(2, 32'h8000_0000, 1, 0, 1);
    start_mask = 4'b0100; stop_mask = 4'b0100; tick();
    start_mask = '0; stop_mask = '0;
    chk("t4_startstop_busy", 32'({busy[2], pwm_out[2]}), 32'h0);
    tick();
    chk("t4_startstop_busy2", 32'(busy[2]), 32'h0);
    cfg_we = 1'b1; cfg_ch = 2'd2; cfg_pat = 32'hFFFF_FFFF;
    start_mask = 4'b0100; tick();
    cfg_we = 1'b0; start_mask = '0;
    chk("t4_old_c1", 32'({busy[2], pwm_out[2]}), 32'h3);
    tick();
    chk("t4_old_c2", 32'(pwm_out[2]), 32'h0);
    repeat (31) tick();
    chk("t4_old_done", 32'({busy[2], done[2]}), 32'h1);
    start_mask = 4'b0100; tick(); start_mask = '0;
    chk("t4_new_c1", 32'({busy[2], pwm_out[2]}), 32'h3);
    tick();
    chk("t4_new_c2", 32'(pwm_out[2]), 32'h1);
    stop_mask = 4'b0100; tick(); stop_mask = '0;
    chk("t4_stop", 32'({busy[2], pwm_out[2], done[2]}), 32'h0);

    // Reset in the middle of burst 2 of 5 on ch3; shadows go back to defaults.
    write_cfg(3, 32'hF000_0000, 1, 0, 5);
    start_mask = 4'b1000; tick(); start_mask = '0;
    repeat (39) tick();
    chk("t5_busy_pre", 32'(busy[3]), 32'h1);
    rst = 1'b1; tick();
    chk("t5_rst_pwm", 32'(pwm_out), 32'h0);
    chk("t5_rst_busy", 32'(busy), 32'h0);
    chk("t5_rst_done", 32'(done), 32'h0);
    rst = 1'b0; tick();
    chk("t5_post_done", 32'({busy, done}), 32'h0);
    start_mask = 4'b1000; tick(); start_mask = '0;
    chk("t5_def_c1", 32'({busy[3], pwm_out[3]}), 32'h2);
    repeat (31) tick();
    chk("t5_def_c32", 32'({busy[3], pwm_out[3], done[3]}), 32'h4);
    tick();
    chk("t5_def_c33", 32'({busy[3], done[3]}), 32'h1);

`ifdef PATTERN_PWM_BANK_POLARITY_EN
    // Inverted channel: idle high, one low clock then 31 high.
    cfg_pol = 1'b1;
    write_cfg(0, 32'h8000_0000, 1, 0, 1);
    cfg_pol = 1'b0;
    chk("t6_idle", 32'(pwm_out[0]), 32'h1);
    start_mask = 4'b0001; tick(); start_mask = '0;
    for (int k = 1; k <= 32; k++) begin
      chk($sformatf("t6_c%0d", k), 32'(pwm_out[0]), (k == 1) ? 32'h0 : 32'h1);
      tick();
    end
    chk("t6_done", 32'({done[0], pwm_out[0]}), 32'h3);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pattern_pwm_bank.md
# pattern_pwm_bank

Parametrised multi-channel pattern PWM engine, successor to the single-channel pattern generator fed by the UART register mapper. Holds per-channel shadow configuration (pattern word, bit period, inter-burst gap, burst count), starts any subset of channels on the same clock edge, and reports per-channel busy/done status. It sits between the UART register mapper and the output buffers/DAC path.

## Interface
- NUM_CHANNELS, 4, number of independent channels (1..16)
- PAT_WIDTH, 32, pattern word width in bits
- DUTY_W, 8, bit-period counter width
- GAP_W, 16, inter-burst gap counter width
- NUM_W, 8, burst count width
- clk  in  1  single clock for all logic
- rst  in  1  synchronous, active-high reset
- cfg_we  in  1  write strobe for one channel's shadow config
- cfg_ch  in  $clog2(NUM_CHANNELS)  target channel; out-of-range values are ignored
- cfg_pat  in  PAT_WIDTH  pattern, emitted MSB first
- cfg_duty  in  DUTY_W  clocks per pattern bit; 0 is treated as 1
- cfg_gap  in  GAP_W  low clocks after each burst; 0 means no gap
- cfg_num  in  NUM_W  burst count; 0 means infinite
- start_mask  in  NUM_CHANNELS  one-cycle start request per channel
- stop_mask  in  NUM_CHANNELS  one-cycle abort request per channel
- pwm_out  out  NUM_CHANNELS  registered pattern outputs
- busy  out  NUM_CHANNELS  channel is running
- done  out  NUM_CHANNELS  one-cycle pulse when a finite run completes

## Operation
- Per-channel FSM with states IDLE, BIT, GAP.
- IDLE:
  - on a start bit, copy the shadow config into active registers, load the shift register with PAT, and go to BIT.
  - A start to a busy channel is ignored.
- BIT:
  - output the current shift MSB for duty clocks, then shift left.
  - After PAT_WIDTH bits, go to GAP if gap ≠ 0; otherwise do the end-of-burst check.
- GAP: output 0 for gap clocks, then do the end-of-burst check.
- End-of-burst check:
  - increment the burst counter.
  - If num ≠ 0 and the count equals num, return to IDLE and pulse done.
  - Otherwise reload PAT and re-enter BIT.
- Infinite mode (num = 0) never pulses done. The burst counter wraps silently.
- stop_mask:
  - the channel goes to IDLE on the next edge with pwm_out = 0.
  - No done pulse is generated.
  - Stop on an idle channel has no effect.
- Simultaneous start and stop on the same channel: stop wins and the channel stays IDLE.
- cfg_we in the same cycle as a start on the same channel: the start latches the pre-write shadow, and the new values apply to the next start.
- Shadow writes while busy never disturb the running burst.
- Reset values:
  - pwm_out = 0, busy = 0, done = 0, all FSMs in IDLE.
  - Shadows: pat = 0, duty = 1, gap = 0, num = 1.
  - Reset mid-run aborts immediately with no done pulse.

## Timing
- Start sampled at edge N: busy = 1 and pwm_out = PAT[MSB] from edge N+1.
- One burst lasts PAT_WIDTH × max(duty, 1) + gap clocks, with no idle cycle between back-to-back bursts.
- done is high for exactly one cycle, at the same edge where busy falls. pwm_out is already 0 at that edge.
- Stop at edge N: busy = 0 and pwm_out = 0 from N+1.
- A new start is accepted in the cycle after busy falls.

## Configuration
- PATTERN_PWM_BANK_POLARITY_EN
  - Defined: adds a 1-bit cfg_pol port written with the other shadow fields. The active channel's pwm_out is XORed with the latched polarity, and the idle/reset level equals the shadow polarity (reset 0).
  - Undefined: the port is absent and outputs are active-high with idle level 0.

## Structure
- Package pattern_pwm_pkg holds:
  - the FSM state enum (IDLE, BIT, GAP);
  - default width constants;
  - a per-channel config struct {pat, duty, gap, num[, pol]}.
- Sub-module pattern_pwm_chan implements one channel (shadow registers, FSM, counters).
- The top level generates NUM_CHANNELS instances and decodes cfg_ch into per-channel write enables.

## Test plan
- Single channel, ch0: PAT = 0xA000_0000, duty = 2, gap = 4, num = 1, start.
  - pwm_out = 1,1,0,0,1,1 then 0 for the remaining 58 + 4 clocks.
  - done pulses at clock 69; busy is high for 68 cycles.
- Synchronous start: ch0–ch3 with identical config, start_mask = 4'b1111.
  - All four pwm_out bits are identical on every cycle and all done pulses coincide.
- Infinite mode: ch1 with num = 0, gap = 0, PAT = 0xFFFF_0000, duty = 1.
  - Continuous 16-high/16-low output for 1000 clocks with no done.
  - stop_mask[1] drops busy and pwm_out on the next edge.
- Collisions on ch2 while idle:
  - start + stop in the same cycle leaves busy = 0.
  - cfg_we (PAT = 0xFFFF_FFFF) + start uses the old PAT, and a second start uses the new one.
- Reset mid-run on ch3 at burst 2 of num = 5: all outputs return to 0 next edge, no done pulse, and the shadow returns to its defaults.
- With PATTERN_PWM_BANK_POLARITY_EN, cfg_pol = 1:
  - idle pwm_out = 1, and PAT = 0x8000_0000 with duty = 1 produces one low clock followed by 31 high clocks.
